// File: rtl/gun_pkg.sv
// gun_pkg: shared types and default constants for the light-gun input front end.
package gun_pkg;
    typedef enum logic [1:0] {DB_LOW, DB_RISE, DB_HIGH, DB_FALL} db_state_t;
    localparam int unsigned SCREEN_PIXELS       = 640 * 480;
    localparam int unsigned CNT_W_DEF           = $clog2(SCREEN_PIXELS + 1);
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
    localparam int unsigned HIT_MIN_DEF         = 64;
    localparam int unsigned AMBIENT_MAX_DEF     = 200000;
endpackage

// File: rtl/gun_input_frontend_if.sv
// gun_input_frontend_if: gun connector pins and timing inputs in, conditioned trigger/detect out.
interface gun_input_frontend_if import gun_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             trigger_raw;
    logic             photo_raw;
    logic             valid;
    logic             frame_tick;
    logic             trigger;
    logic             trigger_rise;
    logic             detect;
    logic             ambient;
    logic [CNT_W-1:0] photo_count;
    modport master (
        output trigger_raw, photo_raw, valid, frame_tick,
        input  trigger, trigger_rise, detect, ambient, photo_count
    );
    modport slave (
        input  trigger_raw, photo_raw, valid, frame_tick,
        output trigger, trigger_rise, detect, ambient, photo_count
    );
endinterface

// File: rtl/input_debouncer.sv
// input_debouncer: 2-FF synchroniser plus debounce FSM producing a clean level and a rise pulse.
// The level/rise outputs are decoded from the registered FSM so the edge lands 2 + DEBOUNCE_CYCLES clocks after the pin.
module input_debouncer import gun_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync;
    logic s, done;
    db_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    assign s    = sync[1] ^ ACTIVE_LOW;
    assign done = cnt == LAST;
    // Synchroniser clears to the inactive pin level so a held input re-qualifies from scratch.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync  <= {2{ACTIVE_LOW}};
            state <= DB_LOW;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rise     = 1'b0;
        level    = state == DB_HIGH || state == DB_FALL;
        case (state)
            DB_LOW:  if (s) begin
                         state_nx = DB_RISE;
                         cnt_nx   = '0;
                     end
            DB_RISE: if (!s) state_nx = DB_LOW;
                     else if (done) begin
                         state_nx = DB_HIGH;
                         level    = 1'b1;
                         rise     = 1'b1;
                     end else cnt_nx = cnt + 1'b1;
            DB_HIGH: if (!s) begin
                         state_nx = DB_FALL;
                         cnt_nx   = '0;
                     end
            DB_FALL: if (s) state_nx = DB_HIGH;
                     else if (done) begin
                         state_nx = DB_LOW;
                         level    = 1'b0;
                     end else cnt_nx = cnt + 1'b1;
            default: state_nx = DB_LOW;
        endcase
    end
endmodule

// File: rtl/gun_input_frontend.sv
// gun_input_frontend: debounced trigger plus per-frame photodiode hit/ambient classification.
module gun_input_frontend import gun_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W            = CNT_W_DEF,
    parameter int unsigned HIT_MIN          = HIT_MIN_DEF,
    parameter int unsigned AMBIENT_MAX      = AMBIENT_MAX_DEF,
    parameter bit          TRIG_ACTIVE_LOW  = 1'b1,
    parameter bit          PHOTO_ACTIVE_LOW = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    gun_input_frontend_if.slave bus
);
    logic [1:0]       photo_sync;
    logic             photo_s;
    logic [CNT_W-1:0] frame_cnt;
    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (TRIG_ACTIVE_LOW)
    ) u_trig (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.trigger_raw),
        .level(bus.trigger),
        .rise (bus.trigger_rise)
    );
    assign photo_s = photo_sync[1] ^ PHOTO_ACTIVE_LOW;
    // The sample coincident with frame_tick belongs to neither frame and is dropped.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            photo_sync      <= {2{PHOTO_ACTIVE_LOW}};
            frame_cnt       <= '0;
            bus.photo_count <= '0;
            bus.detect      <= 1'b0;
            bus.ambient     <= 1'b0;
        end else begin
            photo_sync <= {photo_sync[0], bus.photo_raw};
            if (bus.frame_tick) begin
                bus.photo_count <= frame_cnt;
                bus.detect      <= 32'(frame_cnt) >= HIT_MIN && 32'(frame_cnt) <= AMBIENT_MAX;
                bus.ambient     <= 32'(frame_cnt) > AMBIENT_MAX;
                frame_cnt       <= '0;
            end else if (bus.valid && photo_s && frame_cnt != '1)
                frame_cnt <= frame_cnt + 1'b1;
        end
endmodule

// File: doc/gun_input_frontend.md
Name: gun_input_frontend

Overview:
- Conditions the light-gun inputs before they reach the game/pattern logic.
- Trigger path: synchronises and debounces the raw trigger switch into a clean level plus a one-cycle rise pulse.
- Photodiode path: counts bright pixel-clock samples during the active video of each frame. At each frame boundary it reports detect (gun saw the white hit-box frame) or ambient (gun aimed at a lamp/window).
- Sits between the gun connector pins and the pattern generator's trigger/detect inputs, in the pixel-clock domain.

Parameters:
- DEBOUNCE_CYCLES, 250000, stable clocks required before the trigger level changes (10 ms at 25 MHz).
- CNT_W, 19, width of the photodiode sample counter; must hold 640*480.
- HIT_MIN, 64, minimum bright samples in one frame for detect.
- AMBIENT_MAX, 200000, bright-sample count above which the frame is classed as ambient light.
- TRIG_ACTIVE_LOW, 1, 1 = raw trigger pin is low when pulled.
- PHOTO_ACTIVE_LOW, 0, 1 = photodiode pin is low when light is seen.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- trigger_raw  in  1  raw trigger pin, asynchronous
- photo_raw  in  1  raw photodiode pin, asynchronous
- valid  in  1  active-video qualifier from the VGA timing generator
- frame_tick  in  1  one-clk pulse at each frame boundary, coincident with the screen_reset rising edge
- trigger  out  1  debounced trigger level, active-high
- trigger_rise  out  1  one-clk pulse on each debounced 0->1 transition
- detect  out  1  last completed frame was a hit; held for one full frame
- ambient  out  1  last completed frame exceeded AMBIENT_MAX
- photo_count  out  CNT_W  bright-sample count of the last completed frame (debug)

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs are 0;
  - synchronisers, counters and the debounce FSM are cleared to DB_LOW;
  - the current frame's count is discarded.
- Synchronisers: each raw pin passes through a 2-FF synchroniser, then polarity is normalised to active-high (trig_s, photo_s).
- Debounce FSM states:
  - DB_LOW: trig_s=1 -> DB_RISE, db_cnt<=0.
  - DB_RISE:
    - trig_s=0 -> DB_LOW.
    - Otherwise db_cnt++.
    - At db_cnt==DEBOUNCE_CYCLES-1 -> DB_HIGH; trigger<=1 and trigger_rise<=1 for exactly one cycle.
  - DB_HIGH: trig_s=0 -> DB_FALL, db_cnt<=0.
  - DB_FALL:
    - trig_s=1 -> DB_HIGH.
    - Otherwise db_cnt++.
    - At DEBOUNCE_CYCLES-1 -> DB_LOW; trigger<=0. No fall pulse.
  - A glitch shorter than DEBOUNCE_CYCLES never changes trigger.
  - Latency from pin edge to trigger edge: 2 + DEBOUNCE_CYCLES clocks.
- Photo counter:
  - Each cycle with valid && photo_s && !frame_tick, frame_cnt increments.
  - It saturates at 2^CNT_W-1 (no wrap).
- On frame_tick:
  - photo_count<=frame_cnt;
  - detect<=(frame_cnt>=HIT_MIN)&&(frame_cnt<=AMBIENT_MAX);
  - ambient<=(frame_cnt>AMBIENT_MAX);
  - frame_cnt<=0.
  - The sample in the tick cycle itself is discarded.
  - New outputs are visible the cycle after the tick and hold until the next tick.
- frame_tick on two consecutive cycles: the second tick reports count 0 (detect=0, ambient=0).
- Samples with valid=0 are never counted, so blanking intervals are ignored.
- Trigger and photo paths are fully independent; simultaneous events need no arbitration.
- Reset asserted mid-frame: the next frame_tick after release reports only the samples seen since release.
- Reset asserted mid-debounce: trigger returns to 0. After release, a held trigger needs a full 2 + DEBOUNCE_CYCLES before trigger rises, and trigger_rise fires once.

Decomposition:
- gun_pkg holds:
  - the enum db_state_t {DB_LOW, DB_RISE, DB_HIGH, DB_FALL};
  - default constants for DEBOUNCE_CYCLES, HIT_MIN and AMBIENT_MAX;
  - the screen pixel count (640*480) used to size CNT_W.
- Sub-module input_debouncer: synchroniser plus debounce FSM, parameterised by DEBOUNCE_CYCLES and polarity. It is instantiated once for the trigger and stays reusable for a future second gun.
- The photo counter and frame latch stay in the top.

Test Plan (DEBOUNCE_CYCLES=8, HIT_MIN=4, AMBIENT_MAX=20, CNT_W=8, TRIG_ACTIVE_LOW=1):
- Clean pull: trigger_raw 1->0 and held -> trigger rises exactly 10 clocks after the pin edge; trigger_rise is high for exactly 1 clock. On release, trigger falls 10 clocks after the pin edge with no pulse.
- Bounce: trigger_raw low for 5 clocks, high for 2, then low and held -> trigger stays 0 during the bounce and rises 10 clocks after the last falling edge; only one trigger_rise.
- Hit frame: photo_raw active for 6 valid cycles plus 3 blanking cycles, then frame_tick -> next cycle photo_count=6, detect=1, ambient=0. A following frame with 0 samples -> detect=0.
- Threshold edges, one frame each: 3 samples -> detect=0; 4 -> detect=1; 20 -> detect=1, ambient=0; 21 -> detect=0, ambient=1.
- Saturation: photo active and valid for 300 cycles -> photo_count=255, ambient=1, no wrap to a small value.
- Async reset: assert rst=0 mid-frame after 10 samples with trigger debounced high -> all outputs 0 immediately. Release rst, give 2 samples, then frame_tick -> photo_count=2. The held trigger re-rises 10 clocks after release with one trigger_rise.
